// File: rtl/counter_pkg.sv
// counter_pkg: shared counter types and parameter legality check
package counter_pkg;
  localparam int CNT_W_DEFAULT = 4;
  typedef logic [CNT_W_DEFAULT-1:0] count_t;
  function automatic bit params_ok(input int width, input longint unsigned reset_val, input longint unsigned step);
    longint unsigned lim;
    lim = (width >= 1 && width <= 32) ? (64'd1 << width) : 64'd0;
    return lim != 0 && step != 0 && step < lim && reset_val < lim;
  endfunction
endpackage

// File: rtl/nibble_down_counter_dec.sv
// nibble_down_counter_dec: WIDTH-bit subtract of a constant step, borrow discarded
module nibble_down_counter_dec #(
  parameter int WIDTH = 4,
  parameter longint unsigned STEP = 1
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  assign y = a - STEP_W;
endmodule

// File: rtl/nibble_down_counter.sv
// nibble_down_counter: free-running down counter wrapping modulo 2^WIDTH
module nibble_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT,
  parameter longint unsigned RESET_VAL = 0,
  parameter longint unsigned STEP = 1
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [WIDTH-1:0] out
);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
  if (!params_ok(WIDTH, RESET_VAL, STEP)) begin : g_bad_params
    $fatal(1, "nibble_down_counter: illegal WIDTH/RESET_VAL/STEP");
  end
  logic [WIDTH-1:0] nxt;
  nibble_down_counter_dec #(.WIDTH(WIDTH), .STEP(STEP)) u_dec (.a(out), .y(nxt));
  // an unknown rstn yields an unknown count rather than silently picking a branch
  always_ff @(posedge clk)
    out <= rstn ? nxt : (!rstn ? RST_W : 'x);
endmodule

// File: tb/tb_nibble_down_counter.sv
// tb_nibble_down_counter: directed checks of the default and a WIDTH=8/STEP=3 build
module tb_nibble_down_counter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] out;
  logic [7:0] out8;
  int nchk = 0;
  int nerr = 0;
  logic [3:0] exp;

  nibble_down_counter dut (.clk(clk), .rstn(rstn), .out(out));
  nibble_down_counter #(.WIDTH(8), .RESET_VAL(8'h05), .STEP(3)) dut8 (.clk(clk), .rstn(rstn), .out(out8));

  always #5 clk = ~clk;

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchk++;
      if (out !== 4'h0) begin
        nerr++;
        $display("FAIL reset[%0d]: got %h expected 0", i, out);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_count;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nchk++;
      if (out !== 4'(15 - i)) begin
        nerr++;
        $display("FAIL count[%0d]: got %h expected %h", i, out, 4'(15 - i));
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [3:0] want [2] = '{4'hF, 4'hE};
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nchk++;
      if (out !== 4'h0) begin
        nerr++;
        $display("FAIL mid_reset_hold[%0d]: got %h expected 0", i, out);
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchk++;
      if (out !== want[i]) begin
        nerr++;
        $display("FAIL mid_reset_release[%0d]: got %h expected %h", i, out, want[i]);
      end
    end
  endtask

  task automatic test_wrap;
    int seen [16];
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp = 4'h0;
    foreach (seen[k]) seen[k] = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp = exp - 4'd1;
      if (i < 16) seen[out]++;
      nchk++;
      if (out !== exp) begin
        nerr++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, out, exp);
      end
    end
    for (int k = 0; k < 16; k++) begin
      nchk++;
      if (seen[k] != 1) begin
        nerr++;
        $display("FAIL wrap_visit[%0d]: got %0d visits expected 1", k, seen[k]);
      end
    end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    exp = exp - 4'd1;
    #1 rstn = 1'b0;
    #3 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = exp - 4'd1;
      nchk++;
      if (out !== exp) begin
        nerr++;
        $display("FAIL glitch[%0d]: got %h expected %h", i, out, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    nchk++;
    if (out !== 4'h0) begin
      nerr++;
      $display("FAIL b2b_reset: got %h expected 0", out);
    end
    @(negedge clk);
    rstn = 1'b0;
    nchk++;
    if (out !== 4'hF) begin
      nerr++;
      $display("FAIL b2b_first: got %h expected F", out);
    end
    @(negedge clk);
    rstn = 1'b1;
    nchk++;
    if (out !== 4'h0) begin
      nerr++;
      $display("FAIL b2b_rereset: got %h expected 0", out);
    end
    @(negedge clk);
    nchk++;
    if (out !== 4'hF) begin
      nerr++;
      $display("FAIL b2b_again: got %h expected F", out);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] want [3] = '{8'h02, 8'hFF, 8'hFC};
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    nchk++;
    if (out8 !== 8'h05) begin
      nerr++;
      $display("FAIL sweep_reset: got %h expected 05", out8);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if (out8 !== want[i]) begin
        nerr++;
        $display("FAIL sweep[%0d]: got %h expected %h", i, out8, want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_mid_reset();
    test_wrap();
    test_glitch();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
